// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack memory port and strobes exec_en.
// Optional single-step mode via `FETCH_STEP_EN (adds a synchronised `step` input and a HOLD state).
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_STEP_EN
  input  logic        step,
`endif
  input  logic        halt,
  input  logic        Jump,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] SignImm,
  input  logic [31:0] RegJr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instr,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic        exec_en,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_FAULT
`ifdef FETCH_STEP_EN
    , S_HOLD
`endif
  } state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(ACK_TIMEOUT);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [9:0]  r_waitCnt;
  logic [9:0]  w_cntInc;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_nextPc;
  logic [31:0] w_jrTarget;
  logic        w_stepRise;

`ifdef FETCH_STEP_EN
  logic [1:0] r_stepSync;
  logic       r_stepPrev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stepSync <= 2'b00;
      r_stepPrev <= 1'b0;
    end else begin
      r_stepSync <= {r_stepSync[0], step};
      r_stepPrev <= r_stepSync[1];
    end
  end

  assign w_stepRise = r_stepSync[1] & ~r_stepPrev;
`else
  assign w_stepRise = 1'b0;
`endif

  assign w_pcPlus4  = r_pc + 32'd4;
  assign w_cntInc   = r_waitCnt + 10'd1;
  assign w_jrTarget = RegJr & ~32'h0000_0003;

  // Next-PC selection, Jr highest priority; all arithmetic wraps modulo 2^32.
  always_comb begin
    w_nextPc = w_pcPlus4;
    if (Jr)
      w_nextPc = w_jrTarget;
    else if (Jal || Jump)
      w_nextPc = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};
    else if (Branch && Zero)
      w_nextPc = w_pcPlus4 + (SignImm << 2);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH: if (!halt) w_nextState = S_WAIT;
      // An ack on the timeout edge still wins.
      S_WAIT: begin
        if (imem_ack)
          w_nextState = S_EXEC;
        else if (w_cntInc == TIMEOUT_CNT)
          w_nextState = S_FAULT;
      end
`ifdef FETCH_STEP_EN
      S_EXEC:  w_nextState = S_HOLD;
      S_HOLD:  if (w_stepRise) w_nextState = S_FETCH;
`else
      S_EXEC:  w_nextState = S_FETCH;
`endif
      S_FAULT: w_nextState = S_FAULT;
      default: w_nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_waitCnt <= 10'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_FETCH)
        r_waitCnt <= 10'd0;
      else if (r_state == S_WAIT && !imem_ack)
        r_waitCnt <= w_cntInc;
      if (r_state == S_WAIT && imem_ack)
        r_instr <= imem_rdata;
      if (r_state == S_EXEC)
        r_pc <= w_nextPc;
    end
  end

  assign imem_req  = (r_state == S_WAIT);
  assign imem_addr = r_pc;
  assign PC        = r_pc;
  assign PCPlus4   = w_pcPlus4;
  assign Instr     = r_instr;
  assign OP        = r_instr[31:26];
  assign Funct     = r_instr[5:0];
  assign exec_en   = (r_state == S_EXEC);
  assign fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): vector table of fetch/execute records plus
// hand sequences for reset, halt, mid-fetch reset and ack timeout.
module tb_fetch_unit;

  localparam int TIMEOUT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        Jump, Jal, Jr, Branch, Zero;
  logic [31:0] SignImm, RegJr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] PC, PCPlus4, Instr;
  logic [5:0]  OP, Funct;
  logic        exec_en, fault;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          waits;
    logic        jump, jal, jr, branch, zero;
    logic [31:0] signImm;
    logic [31:0] regJr;
    logic [31:0] expNext;
  } vec_t;

  vec_t vecs[15];

  fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .Jump(Jump), .Jal(Jal), .Jr(Jr), .Branch(Branch), .Zero(Zero),
    .SignImm(SignImm), .RegJr(RegJr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .OP(OP), .Funct(Funct),
    .exec_en(exec_en), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Controls are left holding a JR to junk so an out-of-EXEC PC update would show.
  task automatic parkControls;
    Jump = 1'b0; Jal = 1'b0; Jr = 1'b1; Branch = 1'b1; Zero = 1'b1;
    SignImm = 32'h0000_0100; RegJr = 32'hBAD0_0BAC;
  endtask

  task automatic applyStimulus(input vec_t v, input bit haltInWait);
    bit seen = 1'b0;
    int lat = 0;
    int reqCycles;
    logic [31:0] instrWord;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (imem_req) seen = 1'b1;
    end
    checkOutput("reqRise", 32'(seen), 32'd1);
    if (!seen) return;
    checkOutput("reqLatency", lat, 1);
    checkOutput("imemAddr", imem_addr, v.pc);
    if (haltInWait) halt = 1'b1;
    reqCycles = 1;
    for (int w = 0; w < v.waits; w++) begin
      @(negedge clk);
      if (imem_req) reqCycles++;
    end
    imem_ack = 1'b1;
    imem_rdata = v.instr;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_req) reqCycles++;
    instrWord = v.instr;
    checkOutput("reqCycles", reqCycles, v.waits + 1);
    checkOutput("execEn", 32'(exec_en), 32'd1);
    checkOutput("execPC", PC, v.pc);
    checkOutput("execPCPlus4", PCPlus4, v.pc + 32'd4);
    checkOutput("execInstr", Instr, instrWord);
    checkOutput("execOP", 32'(OP), 32'(instrWord[31:26]));
    checkOutput("execFunct", 32'(Funct), 32'(instrWord[5:0]));
    Jump = v.jump; Jal = v.jal; Jr = v.jr; Branch = v.branch; Zero = v.zero;
    SignImm = v.signImm; RegJr = v.regJr;
    @(negedge clk);
    parkControls();
    checkOutput("execOnce", 32'(exec_en), 32'd0);
    checkOutput("nextPC", PC, v.expNext);
    checkOutput("reqLowAfterExec", 32'(imem_req), 32'd0);
  endtask

  initial begin
    int reqCycles;
    bit sawReq;
    bit sawExec;

    //          pc             instr          w  J  JL JR B  Z  SignImm        RegJr          next
    vecs[0]  = '{32'h0000_0000, 32'h0109_5020, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0004};
    vecs[1]  = '{32'h0000_0004, 32'h0800_0002, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008};
    vecs[2]  = '{32'h0000_0008, 32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFE, 32'h0,         32'h0000_0004};
    vecs[3]  = '{32'h0000_0004, 32'h0800_0002, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008};
    vecs[4]  = '{32'h0000_0008, 32'h1000_FFFE, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE, 32'h0,         32'h0000_000C};
    vecs[5]  = '{32'h0000_000C, 32'h03E0_0008, 0, 0, 0, 1, 0, 0, 32'h0,         32'h1000_0013, 32'h1000_0010};
    vecs[6]  = '{32'h1000_0010, 32'h0C00_0040, 0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h1000_0100};
    vecs[7]  = '{32'h1000_0100, 32'h03E0_0008, 2, 0, 0, 1, 0, 0, 32'h0,         32'h0000_0203, 32'h0000_0200};
    vecs[8]  = '{32'h0000_0200, 32'h0109_5020, 3, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0204};
    vecs[9]  = '{32'h0000_0204, 32'h03E0_0008, 0, 0, 0, 1, 0, 0, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0000};
    vecs[11] = '{32'h0000_0000, 32'h1000_0003, 5, 0, 0, 0, 1, 1, 32'h0000_0003, 32'h0,         32'h0000_0010};
    vecs[12] = '{32'h0000_0010, 32'h0C00_0111, 0, 1, 1, 1, 1, 1, 32'h0000_0001, 32'h0000_0040, 32'h0000_0040};
    vecs[13] = '{32'h0000_0040, 32'h0800_0100, 0, 1, 0, 0, 1, 1, 32'h0000_0005, 32'h0,         32'h0000_0400};
    vecs[14] = '{32'h0000_0400, 32'h0109_5020, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0404};

    rst_n = 1'b0;
    halt = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    parkControls();
    repeat (2) @(negedge clk);
    checkOutput("resetPC", PC, 32'h0);
    checkOutput("resetReq", 32'(imem_req), 32'd0);
    checkOutput("resetInstr", Instr, 32'h0);
    checkOutput("resetExec", 32'(exec_en), 32'd0);
    checkOutput("resetFault", 32'(fault), 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], 1'b0);
    applyStimulus(vecs[14], 1'b1);

    // Halt raised mid-WAIT: that instruction ran, nothing new may issue; stray acks ignored.
    sawReq = 1'b0;
    sawExec = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req) sawReq = 1'b1;
      if (exec_en) sawExec = 1'b1;
      imem_ack = (i == 1);
      imem_rdata = 32'hFFFF_FFFF;
    end
    imem_ack = 1'b0;
    checkOutput("haltNoReq", 32'(sawReq), 32'd0);
    checkOutput("haltNoExec", 32'(sawExec), 32'd0);
    checkOutput("haltInstrKept", Instr, 32'h0109_5020);
    checkOutput("haltPCKept", PC, 32'h0000_0404);
    halt = 1'b0;

    // Reset pulsed in the middle of a WAIT.
    sawReq = 1'b0;
    for (int i = 0; i < 4 && !sawReq; i++) begin
      @(negedge clk);
      if (imem_req) sawReq = 1'b1;
    end
    checkOutput("resumeReq", 32'(sawReq), 32'd1);
    checkOutput("resumeAddr", imem_addr, 32'h0000_0404);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("midResetReq", 32'(imem_req), 32'd0);
    checkOutput("midResetPC", PC, 32'h0);
    @(negedge clk);
    checkOutput("midResetInstr", Instr, 32'h0);
    checkOutput("midResetReqHeld", 32'(imem_req), 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    applyStimulus(vecs[0], 1'b0);

    // Never-acking memory: FAULT after TIMEOUT WAIT cycles, sticky until reset.
    reqCycles = 0;
    sawExec = 1'b0;
    for (int i = 0; i < 20 && !fault; i++) begin
      @(negedge clk);
      if (imem_req) reqCycles++;
      if (exec_en) sawExec = 1'b1;
    end
    checkOutput("timeoutFault", 32'(fault), 32'd1);
    checkOutput("timeoutReqCycles", reqCycles, TIMEOUT);
    checkOutput("timeoutReqLow", 32'(imem_req), 32'd0);
    checkOutput("timeoutPC", PC, 32'h0000_0004);
    checkOutput("timeoutNoExec", 32'(sawExec), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("faultSticky", 32'(fault), 32'd1);
    checkOutput("faultNoExec", 32'(exec_en), 32'd0);
    checkOutput("faultPCFrozen", PC, 32'h0000_0004);
    checkOutput("faultInstrKept", Instr, 32'h0109_5020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
